amo_responder: RTL
==================

AMO_RESPONDER -- requirements
Module: amo_responder

Interface
REQ-001 SHALL have parameter RES_GRAN_LOG2, default 3, meaning log2 of the LR/SC reservation granule in bytes.
REQ-002 SHALL have port clk_i, input, 1, clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, reset; one clock, and reset is asynchronous and active-low.
REQ-004 SHALL have port amo_req_i, input, amo_req_t, AMO request {req, amo_op, size, operand_a = physical address, operand_b = store data}.
REQ-005 SHALL have port amo_resp_o, output, amo_resp_t, AMO response {ack, result}.
REQ-006 SHALL have port mem_req_o, output, 1, memory-side request valid.
REQ-007 SHALL have port mem_we_o, output, 1, write enable (1 = write, 0 = read).
REQ-008 SHALL have port mem_addr_o, output, 64, doubleword-aligned address (operand_a with bits [2:0] cleared).
REQ-009 SHALL have port mem_wdata_o, output, 64, write data.
REQ-010 SHALL have port mem_be_o, output, 8, byte enables.
REQ-011 SHALL have port mem_gnt_i, input, 1, grant; the request is accepted in a cycle where mem_req_o and mem_gnt_i are both high.
REQ-012 SHALL have port mem_rvalid_i, input, 1, read data valid.
REQ-013 SHALL have port mem_rdata_i, input, 64, read data.

Function
REQ-014 SHALL implement the states IDLE, READ, WAIT_RDATA, WRITE and RESP.
REQ-015 IDLE with amo_req_i.req high SHALL latch op, address, data and size in that cycle.
REQ-016 Transitions out of IDLE on a request SHALL be:
- AMO_NONE -> RESP, with result 0 and no memory access.
- AMO_SC with the reservation hit -> WRITE.
- AMO_SC with the reservation missed -> RESP, with result 1.
- any other op -> READ.
REQ-017 A reservation hit SHALL mean reservation valid and address[63:RES_GRAN_LOG2] equal to the stored reservation address.
REQ-018 READ SHALL drive mem_req_o=1 and mem_we_o=0, and move to WAIT_RDATA on grant.
REQ-019 WAIT_RDATA SHALL capture the old value on mem_rvalid_i, then:
- for LR, set the reservation to the latched address and go to RESP;
- otherwise go to WRITE.
REQ-020 WRITE SHALL drive mem_req_o=1 and mem_we_o=1, hold all memory outputs stable until grant, then go to RESP.
REQ-021 RESP SHALL assert amo_resp_o.ack for exactly one cycle, then return to IDLE.
REQ-022 The requester holds req until ack; a request seen in the ack cycle SHALL be ignored.
REQ-023 Write data SHALL be computed as:
- SWAP/SC: operand_b
- ADD: old + operand_b, modulo operand width
- AND/OR/XOR: bitwise
- MAX/MIN: signed compare
- MAXU/MINU: unsigned compare
REQ-024 Word operations (size 2'b10) SHALL:
- use address bit 2 to select the half;
- drive mem_be_o to 8'h0F or 8'hF0;
- place the 32-bit write value in the selected half;
- compare and add on 32 bits only.
REQ-025 Doubleword operations (size 2'b11) SHALL drive mem_be_o to 8'hFF.
REQ-026 The result SHALL be:
- the old memory value for LR and read-modify-write AMOs, sign-extended from 32 bits for word operations;
- 0 for a successful SC;
- 1 for a failed SC.
REQ-027 Any SC, success or failure, SHALL clear the reservation.
REQ-028 Any AMO write whose address hits the reservation SHALL clear it.
REQ-029 A new LR SHALL overwrite the reservation.
REQ-030 mem_rvalid_i outside WAIT_RDATA SHALL be ignored.
REQ-031 Latency with same-cycle grant and rvalid one cycle after grant, counted from the request cycle (cycle 0) to the ack cycle, SHALL be:
- SC fail or AMO_NONE: ack in cycle 1
- SC success: ack in cycle 2
- LR: ack in cycle 3
- read-modify-write AMO: ack in cycle 4
REQ-032 Outputs SHALL be registered state decodes, with no combinational path from amo_req_i to mem_* outputs.

Reset
REQ-033 Reset SHALL force state IDLE, clear the reservation and all latched operands, and drive ack=0, result=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0.
REQ-034 Reset asserted mid-operation SHALL abort the operation without issuing an ack.
REQ-035 A write already granted before that reset SHALL NOT be retracted.

Verification
REQ-036 LR.D at 0x1000, memory = 0xDEAD_BEEF_0000_0001 -> ack in cycle 3, result 0xDEADBEEF00000001, reservation set.
REQ-037 LR.D at 0x1000 followed by SC.D at 0x1000 with data 0x55 -> SC ack in cycle 2, result 0, memory = 0x55, mem_be_o = 8'hFF.
REQ-038 SC.D at 0x2000 with no reservation -> ack in cycle 1, result 1, no mem_req_o asserted.
REQ-039 AMOADD.W at 0x1004, memory upper word 0x7FFFFFFF, operand 1 -> write 0x80000000 with be 8'hF0, result 0x000000007FFFFFFF.
REQ-040 AMOMAX.W vs AMOMAXU.W with old 0xFFFFFFFF and operand 1 -> signed writes 1, unsigned writes 0xFFFFFFFF, both return 0xFFFFFFFFFFFFFFFF.
REQ-041 mem_gnt_i held low for 5 cycles in WRITE -> mem_* outputs stable throughout; rst_ni pulsed low in WAIT_RDATA -> IDLE, no ack, reservation cleared.

Source files
------------

// File: rtl/amo_responder.sv
// Atomic memory op responder (LR/SC + RMW AMOs); ack 1/2/3/4 cycles after request for SC-fail|NONE/SC/LR/RMW.
// Backpressure: holds mem_* outputs until mem_gnt_i; the requester holds req until the one-cycle ack.
package amo_pkg;
  typedef enum logic [3:0] {
    AMO_NONE, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND,
    AMO_OR, AMO_XOR, AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU
  } amo_op_t;

  typedef struct packed {
    logic        req;
    amo_op_t     amo_op;
    logic [1:0]  size;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
  } amo_req_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] result;
  } amo_resp_t;
endpackage

module amo_responder
  import amo_pkg::*;
#(
  parameter int unsigned RES_GRAN_LOG2 = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  amo_req_t    amo_req_i,
  output amo_resp_t   amo_resp_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, READ, WAIT_RDATA, WRITE, RESP} state_t;

  state_t      state_q;
  amo_op_t     op_q;
  logic [1:0]  size_q;
  logic [63:0] addr_q;
  logic [63:0] data_q;
  logic        res_vld_q;
  logic [63-RES_GRAN_LOG2:0] res_addr_q;
  logic        ack_q;
  logic [63:0] result_q;

  logic        is_word_q;
  logic [31:0] old_w;
  logic [63:0] old_ext;
  logic [63:0] new_d;
  logic [31:0] new_w;
  logic [63:0] wdata_rmw;
  logic        res_hit_req;
  logic        res_hit_q;
  logic        unused_addr_lsb;

  function automatic logic [7:0] be_of(input logic [1:0] size, input logic a2);
    if (size == 2'b10) return a2 ? 8'hF0 : 8'h0F;
    return 8'hFF;
  endfunction

  function automatic logic [63:0] place(input logic [1:0] size, input logic a2,
                                        input logic [63:0] val);
    if (size == 2'b10) return a2 ? {val[31:0], 32'h0} : {32'h0, val[31:0]};
    return val;
  endfunction

  assign amo_resp_o.ack    = ack_q;
  assign amo_resp_o.result = result_q;
  assign unused_addr_lsb   = ^{amo_req_i.operand_a[1:0], addr_q[1:0]};

  assign is_word_q   = (size_q == 2'b10);
  assign old_w       = addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
  assign old_ext     = is_word_q ? {{32{old_w[31]}}, old_w} : mem_rdata_i;
  assign res_hit_req = res_vld_q && (amo_req_i.operand_a[63:RES_GRAN_LOG2] == res_addr_q);
  assign res_hit_q   = res_vld_q && (addr_q[63:RES_GRAN_LOG2] == res_addr_q);

  // Both widths are computed; the word result only ever lands in the addressed half.
  always_comb begin
    new_d = data_q;
    new_w = data_q[31:0];
    case (op_q)
      AMO_ADD: begin
        new_d = mem_rdata_i + data_q;
        new_w = old_w + data_q[31:0];
      end
      AMO_AND: begin
        new_d = mem_rdata_i & data_q;
        new_w = old_w & data_q[31:0];
      end
      AMO_OR: begin
        new_d = mem_rdata_i | data_q;
        new_w = old_w | data_q[31:0];
      end
      AMO_XOR: begin
        new_d = mem_rdata_i ^ data_q;
        new_w = old_w ^ data_q[31:0];
      end
      AMO_MAX: begin
        new_d = ($signed(mem_rdata_i) > $signed(data_q)) ? mem_rdata_i : data_q;
        new_w = ($signed(old_w) > $signed(data_q[31:0])) ? old_w : data_q[31:0];
      end
      AMO_MIN: begin
        new_d = ($signed(mem_rdata_i) < $signed(data_q)) ? mem_rdata_i : data_q;
        new_w = ($signed(old_w) < $signed(data_q[31:0])) ? old_w : data_q[31:0];
      end
      AMO_MAXU: begin
        new_d = (mem_rdata_i > data_q) ? mem_rdata_i : data_q;
        new_w = (old_w > data_q[31:0]) ? old_w : data_q[31:0];
      end
      AMO_MINU: begin
        new_d = (mem_rdata_i < data_q) ? mem_rdata_i : data_q;
        new_w = (old_w < data_q[31:0]) ? old_w : data_q[31:0];
      end
      default: ;
    endcase
    wdata_rmw = is_word_q ? place(size_q, addr_q[2], {32'h0, new_w}) : new_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_q        <= AMO_NONE;
      size_q      <= 2'b00;
      addr_q      <= '0;
      data_q      <= '0;
      res_vld_q   <= 1'b0;
      res_addr_q  <= '0;
      ack_q       <= 1'b0;
      result_q    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (amo_req_i.req) begin
            op_q       <= amo_req_i.amo_op;
            size_q     <= amo_req_i.size;
            addr_q     <= amo_req_i.operand_a;
            data_q     <= amo_req_i.operand_b;
            mem_addr_o <= {amo_req_i.operand_a[63:3], 3'b000};
            mem_be_o   <= be_of(amo_req_i.size, amo_req_i.operand_a[2]);
            case (amo_req_i.amo_op)
              AMO_NONE: begin
                result_q <= 64'd0;
                ack_q    <= 1'b1;
                state_q  <= RESP;
              end
              AMO_SC: begin
                res_vld_q <= 1'b0;
                if (res_hit_req) begin
                  result_q    <= 64'd0;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b1;
                  mem_wdata_o <= place(amo_req_i.size, amo_req_i.operand_a[2],
                                       amo_req_i.operand_b);
                  state_q     <= WRITE;
                end else begin
                  result_q <= 64'd1;
                  ack_q    <= 1'b1;
                  state_q  <= RESP;
                end
              end
              default: begin
                mem_req_o <= 1'b1;
                mem_we_o  <= 1'b0;
                state_q   <= READ;
              end
            endcase
          end
        end
        READ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_q   <= WAIT_RDATA;
          end
        end
        WAIT_RDATA: begin
          if (mem_rvalid_i) begin
            result_q <= old_ext;
            if (op_q == AMO_LR) begin
              res_vld_q  <= 1'b1;
              res_addr_q <= addr_q[63:RES_GRAN_LOG2];
              ack_q      <= 1'b1;
              state_q    <= RESP;
            end else begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_wdata_o <= wdata_rmw;
              state_q     <= WRITE;
            end
          end
        end
        WRITE: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (res_hit_q) res_vld_q <= 1'b0;
            ack_q     <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
